// File: rtl/neg_pipe_register_if.sv
// Handshake and data bundle for neg_pipe_register.
// The master side is the upstream or hazard logic that drives data, stall and flush.
// The slave side is the pipeline register itself.
interface neg_pipe_register_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             input_enable;
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [OCC_W-1:0] occupancy;
    logic             overrun;

    modport master (
        output input_enable, in, in_valid, stall, flush,
        input  in_ready, out, out_valid, occupancy, overrun
    );

    modport slave (
        input  input_enable, in, in_valid, stall, flush,
        output in_ready, out, out_valid, occupancy, overrun
    );
endinterface

// File: rtl/neg_pipe_register.sv
// Falling-edge multi-stage pipeline register with per-stage valid bits.
// Supports downstream stall, synchronous flush and optional bubble collapsing.
// Reports occupancy and a sticky overrun flag for debug.
// Stage 0 is on the input side and stage DEPTH-1 drives out.
module neg_pipe_register #(
    parameter int WIDTH           = 32,
    parameter int DEPTH           = 2,
    parameter bit BUBBLE_COLLAPSE = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    neg_pipe_register_if.slave   bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_reg  [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic             overrun_reg;

    // Value each stage would load on a shift: stage 0 takes the input port,
    // and every other stage takes its upstream neighbour.
    logic [WIDTH-1:0] src_data  [DEPTH];
    logic [DEPTH-1:0] src_valid;
    logic [DEPTH-1:0] hold;
    logic             in_ready_next;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
        if (gi == 0) begin : g_head
            assign src_data[gi]  = bus.in;
            assign src_valid[gi] = bus.in_valid;
        end else begin : g_body
            assign src_data[gi]  = data_reg[gi-1];
            assign src_valid[gi] = valid_reg[gi-1];
        end
    end

    // Hold chain. In collapse mode, a stage only holds if it holds a valid word
    // and everything downstream of it is also blocked. This lets bubbles be
    // squeezed out under stall. In freeze mode, stall stops every stage.
    always_comb begin
        hold = '0;
        if (BUBBLE_COLLAPSE) begin
            hold[DEPTH-1] = bus.stall & valid_reg[DEPTH-1];
            for (int i = DEPTH - 2; i >= 0; i--) begin
                hold[i] = valid_reg[i] & hold[i+1];
            end
        end else begin
            hold = {DEPTH{bus.stall}};
        end
    end

    assign in_ready_next = ~hold[0] & bus.input_enable & ~bus.flush;

    // Stage update on the falling edge.
    // Priority is: flush, then the enable gate, then per-stage shift or hold.
    // Data is copied even when its valid bit is 0.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
            end
            valid_reg   <= '0;
            overrun_reg <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
            end
            valid_reg   <= '0;
            overrun_reg <= 1'b0;
        end else if (bus.input_enable) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!hold[i]) begin
                    data_reg[i]  <= src_data[i];
                    valid_reg[i] <= src_valid[i];
                end
            end
            if (bus.in_valid && !in_ready_next) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Occupancy is a population count of the valid bits.
    always_comb begin
        bus.occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.occupancy = bus.occupancy + OCC_W'(valid_reg[i]);
        end
    end

    assign bus.in_ready  = in_ready_next;
    assign bus.out       = data_reg[DEPTH-1];
    assign bus.out_valid = valid_reg[DEPTH-1];
    assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_neg_pipe_register.sv
// Directed bench for neg_pipe_register with WIDTH=8 and DEPTH=3.
// It instantiates two copies, one in collapse mode (dut_c) and one in freeze mode (dut_f).
// Both copies receive identical stimulus.
module tb_neg_pipe_register;
    localparam int W = 8;
    localparam int D = 3;

    logic clock = 1'b1;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic         en_d;
    logic [W-1:0] in_d;
    logic         vld_d;
    logic         stall_d;
    logic         flush_d;

    int n_vec = 0;
    int n_err = 0;

    neg_pipe_register_if #(.WIDTH(W), .DEPTH(D)) c_if ();
    neg_pipe_register_if #(.WIDTH(W), .DEPTH(D)) f_if ();

    assign c_if.input_enable = en_d;
    assign c_if.in           = in_d;
    assign c_if.in_valid     = vld_d;
    assign c_if.stall        = stall_d;
    assign c_if.flush        = flush_d;
    assign f_if.input_enable = en_d;
    assign f_if.in           = in_d;
    assign f_if.in_valid     = vld_d;
    assign f_if.stall        = stall_d;
    assign f_if.flush        = flush_d;

    neg_pipe_register #(.WIDTH(W), .DEPTH(D), .BUBBLE_COLLAPSE(1'b1)) dut_c (
        .clock (clock),
        .reset (reset),
        .bus   (c_if.slave)
    );

    neg_pipe_register #(.WIDTH(W), .DEPTH(D), .BUBBLE_COLLAPSE(1'b0)) dut_f (
        .clock (clock),
        .reset (reset),
        .bus   (f_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [W-1:0] d, input logic v,
                         input logic st, input logic fl);
        en_d = en; in_d = d; vld_d = v; stall_d = st; flush_d = fl;
    endtask

    // Advance past one falling edge and settle.
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    initial begin
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_out",       32'(c_if.out),       32'h0);
        chk("rst_out_valid", 32'(c_if.out_valid), 32'h0);
        chk("rst_occ",       32'(c_if.occupancy), 32'h0);
        chk("rst_in_ready",  32'(c_if.in_ready),  32'h1);
        chk("rst_overrun",   32'(c_if.overrun),   32'h0);
        step();
        reset = 1'b0;

        $display("fill 11/22/33, stall=0");
        drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0); step();
        chk("fill1_occ",   32'(c_if.occupancy), 32'h1);
        chk("fill1_valid", 32'(c_if.out_valid), 32'h0);
        drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 8'h33, 1'b1, 1'b0, 1'b0); step();
        chk("fill3_out",   32'(c_if.out),       32'h11);
        chk("fill3_valid", 32'(c_if.out_valid), 32'h1);
        chk("fill3_occ",   32'(c_if.occupancy), 32'h3);
        chk("fill3_f_out", 32'(f_if.out),       32'h11);
        @(posedge clock); #1;
        chk("posedge_out", 32'(c_if.out),       32'h11);
        chk("posedge_occ", 32'(c_if.occupancy), 32'h3);
        drive(1'b1, 8'h44, 1'b1, 1'b0, 1'b0); step();
        chk("shift4_out", 32'(c_if.out), 32'h22);
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0); step();
        chk("shift5_out", 32'(c_if.out), 32'h33);
        chk("shift5_occ", 32'(c_if.occupancy), 32'h3);

        $display("async reset mid-cycle on full pipe");
        reset = 1'b1; #1;
        chk("arst_out",   32'(c_if.out),       32'h0);
        chk("arst_valid", 32'(c_if.out_valid), 32'h0);
        chk("arst_occ",   32'(c_if.occupancy), 32'h0);
        chk("arst_f_occ", 32'(f_if.occupancy), 32'h0);
        reset = 1'b0;

        $display("build AA / bubble 5A / BB");
        drive(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0); step();
        chk("bub_out", 32'(c_if.out),       32'hAA);
        chk("bub_occ", 32'(c_if.occupancy), 32'h2);
        drive(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0); #1;
        chk("stall_c_rdy", 32'(c_if.in_ready), 32'h1);
        chk("stall_f_rdy", 32'(f_if.in_ready), 32'h0);
        step();
        chk("coll_occ",  32'(c_if.occupancy), 32'h3);
        chk("coll_out",  32'(c_if.out),       32'hAA);
        chk("coll_rdy",  32'(c_if.in_ready),  32'h0);
        chk("coll_ovr",  32'(c_if.overrun),   32'h0);
        chk("frz_ovr",   32'(f_if.overrun),   32'h1);
        chk("frz_occ1",  32'(f_if.occupancy), 32'h2);
        drive(1'b1, 8'hDD, 1'b1, 1'b1, 1'b0); step();
        chk("coll_ovr2", 32'(c_if.overrun),   32'h1);
        chk("coll_out2", 32'(c_if.out),       32'hAA);
        chk("coll_occ2", 32'(c_if.occupancy), 32'h3);
        drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0); step(); step();
        chk("frz_out4",  32'(f_if.out),       32'hAA);
        chk("frz_vld4",  32'(f_if.out_valid), 32'h1);
        chk("frz_occ4",  32'(f_if.occupancy), 32'h2);

        $display("release stall");
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0); step();
        chk("rel1_c_out", 32'(c_if.out),       32'hBB);
        chk("rel1_f_out", 32'(f_if.out),       32'h5A);
        chk("rel1_f_vld", 32'(f_if.out_valid), 32'h0);
        chk("rel1_f_occ", 32'(f_if.occupancy), 32'h1);
        step();
        chk("rel2_f_out", 32'(f_if.out),       32'hBB);
        chk("rel2_f_vld", 32'(f_if.out_valid), 32'h1);
        chk("rel2_c_out", 32'(c_if.out),       32'hCC);
        chk("rel2_c_occ", 32'(c_if.occupancy), 32'h1);

        $display("fill 61/62/63 then flush under stall");
        drive(1'b1, 8'h61, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 8'h62, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 8'h63, 1'b1, 1'b0, 1'b0); step();
        chk("full_occ", 32'(c_if.occupancy), 32'h3);
        chk("full_out", 32'(c_if.out),       32'h61);
        drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b1); #1;
        chk("flush_rdy", 32'(c_if.in_ready), 32'h0);
        step();
        chk("flush_occ",   32'(c_if.occupancy), 32'h0);
        chk("flush_out",   32'(c_if.out),       32'h0);
        chk("flush_vld",   32'(c_if.out_valid), 32'h0);
        chk("flush_ovr",   32'(c_if.overrun),   32'h0);
        chk("flush_f_occ", 32'(f_if.occupancy), 32'h0);
        chk("flush_f_ovr", 32'(f_if.overrun),   32'h0);

        $display("input_enable=0 hold");
        drive(1'b1, 8'h81, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 8'h82, 1'b1, 1'b0, 1'b0); step();
        chk("en_pre_occ", 32'(c_if.occupancy), 32'h2);
        drive(1'b0, 8'h99, 1'b1, 1'b0, 1'b0); #1;
        chk("en0_rdy", 32'(c_if.in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("en0_occ", 32'(c_if.occupancy), 32'h2);
            chk("en0_vld", 32'(c_if.out_valid), 32'h0);
            chk("en0_ovr", 32'(c_if.overrun),   32'h0);
        end
        chk("en0_f_occ", 32'(f_if.occupancy), 32'h2);
        drive(1'b0, 8'h99, 1'b1, 1'b0, 1'b1); step();
        chk("en0_flush_occ",   32'(c_if.occupancy), 32'h0);
        chk("en0_flush_f_occ", 32'(f_if.occupancy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
